// File: rtl/cla_sub_16bit_pipe.sv
// Pipelined 16-bit subtractor: four 4-bit carry-lookahead slices, one per stage,
// with a valid/ready handshake that stalls the whole pipeline on back-pressure.
module cla_sub_16bit_pipe (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] in_1,
   input  logic [15:0] in_2,
   input  logic        b_in,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [15:0] diff,
   output logic        b_out,
   output logic        ovf,
   output logic        zero,
   output logic        o_valid,
   input  logic        i_ready
);

   // One 4-bit lookahead slice: returns {carry_out, sum[3:0]}.
   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                       input logic cin);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      return {c[4], p ^ c[3:0]};
   endfunction

   logic [15:0] r_a [0:4];
   logic [15:0] r_b [0:4];
   logic        r_c [0:4];
   logic [15:0] r_d [1:4];
   logic        r_v [0:4];

   logic [15:0] r_diff;
   logic        r_bOut;
   logic        r_ovf;
   logic        r_zero;
   logic        r_oValid;

   logic [3:0]  w_sum [0:3];
   logic        w_co  [0:3];
   logic [15:0] w_dn  [0:3];
   logic        w_en;

   assign w_en    = i_ready | ~r_oValid;
   assign o_ready = w_en;

   // Slice s works on nibble s of the operands held in stage s; subtraction is a + ~b + ~b_in.
   always_comb begin
      for (int s = 0; s < 4; s++) begin
         {w_co[s], w_sum[s]} = cla4(r_a[s][4*s +: 4], ~r_b[s][4*s +: 4], r_c[s]);
      end
      w_dn[0] = {12'h000, w_sum[0]};
      for (int s = 1; s < 4; s++) begin
         w_dn[s]            = r_d[s];
         w_dn[s][4*s +: 4]  = w_sum[s];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int s = 0; s < 5; s++) begin
            r_a[s] <= '0;
            r_b[s] <= '0;
            r_c[s] <= 1'b0;
            r_v[s] <= 1'b0;
         end
         for (int s = 1; s < 5; s++) begin
            r_d[s] <= '0;
         end
      end else if (w_en) begin
         r_a[0] <= in_1;
         r_b[0] <= in_2;
         r_c[0] <= ~b_in;
         r_v[0] <= i_valid;
         for (int s = 0; s < 4; s++) begin
            r_a[s+1] <= r_a[s];
            r_b[s+1] <= r_b[s];
            r_c[s+1] <= w_co[s];
            r_d[s+1] <= w_dn[s];
            r_v[s+1] <= r_v[s];
         end
      end
   end

   // Result registers update only for a valid final stage, so bubbles leave them untouched.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_oValid <= 1'b0;
         r_diff   <= '0;
         r_bOut   <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b0;
      end else if (w_en) begin
         r_oValid <= r_v[4];
         if (r_v[4]) begin
            r_diff <= r_d[4];
            r_bOut <= ~r_c[4];
            r_ovf  <= (r_a[4][15] != r_b[4][15]) && (r_d[4][15] != r_a[4][15]);
            r_zero <= (r_d[4] == 16'h0000);
         end
      end
   end

   assign diff    = r_diff;
   assign b_out   = r_bOut;
   assign ovf     = r_ovf;
   assign zero    = r_zero;
   assign o_valid = r_oValid;

endmodule

// File: tb/tb_cla_sub_16bit_pipe.sv
// Self-checking bench for cla_sub_16bit_pipe: directed cases, bubbles, stalls,
// randomized handshake traffic and mid-stream reset against an arithmetic model.
module tb_cla_sub_16bit_pipe;

   logic        clk = 1'b0;
   logic        rstN;
   logic [15:0] in1;
   logic [15:0] in2;
   logic        bIn;
   logic        iValid;
   logic        oReady;
   logic [15:0] diffO;
   logic        bOut;
   logic        ovfO;
   logic        zeroO;
   logic        oValid;
   logic        iReady;

   int nVectors     = 0;
   int nMiscompares = 0;
   logic [18:0] expQ [$];

   always #5 clk = ~clk;

   cla_sub_16bit_pipe dut (
      .i_clk   (clk),
      .i_rst_n (rstN),
      .in_1    (in1),
      .in_2    (in2),
      .b_in    (bIn),
      .i_valid (iValid),
      .o_ready (oReady),
      .diff    (diffO),
      .b_out   (bOut),
      .ovf     (ovfO),
      .zero    (zeroO),
      .o_valid (oValid),
      .i_ready (iReady)
   );

   // Reference: plain integer arithmetic, returns {diff, borrow, overflow, zero}.
   function automatic logic [18:0] refSub(input logic [15:0] a, input logic [15:0] b,
                                          input logic bin);
      int ua, ub, ib, ud, sa, sb, sd;
      logic [15:0] d;
      ua = a;
      ub = b;
      ib = bin;
      ud = ua - ub - ib;
      d  = ud[15:0];
      sa = $signed(a);
      sb = $signed(b);
      sd = sa - sb - ib;
      return {d, ud < 0, (sd > 32767) || (sd < -32768), d == 16'h0000};
   endfunction

   task automatic test_reset();
      rstN = 1'b0;
      #2;
      nVectors++;
      if ({oValid, diffO, bOut, ovfO, zeroO} !== 20'h0)
         $display("[TB] FAIL reset_outputs: got %h want %h", {oValid, diffO, bOut, ovfO, zeroO}, 20'h0);
      if ({oValid, diffO, bOut, ovfO, zeroO} !== 20'h0) nMiscompares++;
      nVectors++;
      if (oReady !== 1'b1) begin
         nMiscompares++;
         $display("[TB] FAIL reset_ready: got %b want 1", oReady);
      end
      @(posedge clk);
      #3 rstN = 1'b1;
      @(posedge clk);
      #1;
      nVectors++;
      if (oValid !== 1'b0) begin
         nMiscompares++;
         $display("[TB] FAIL post_reset_valid: got %b want 0", oValid);
      end
   endtask

   task automatic test_directed();
      logic [15:0] tA   [5] = '{16'h1234, 16'h0000, 16'h0005, 16'h8000, 16'h0006};
      logic [15:0] tB   [5] = '{16'h0234, 16'h0001, 16'h0005, 16'h0001, 16'h0005};
      logic        tBin [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [18:0] tExp [5] = '{{16'h1000, 3'b000}, {16'hFFFF, 3'b100}, {16'hFFFF, 3'b100},
                                {16'h7FFF, 3'b010}, {16'h0000, 3'b001}};
      iReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in1 = tA[i];
         in2 = tB[i];
         bIn = tBin[i];
         iValid = 1'b1;
         @(posedge clk);
         #1 iValid = 1'b0;
         repeat (4) @(posedge clk);
         #1;
         nVectors++;
         if (oValid !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL directed%0d_early_valid: got %b want 0", i, oValid);
         end
         @(posedge clk);
         #1;
         nVectors++;
         if ({oValid, diffO, bOut, ovfO, zeroO} !== {1'b1, tExp[i]}) begin
            nMiscompares++;
            $display("[TB] FAIL directed%0d: got v=%b d=%h b=%b o=%b z=%b want v=1 d=%h b=%b o=%b z=%b",
                     i, oValid, diffO, bOut, ovfO, zeroO, tExp[i][18:3], tExp[i][2], tExp[i][1], tExp[i][0]);
         end
      end
   endtask

   task automatic test_bubbles();
      logic        pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [15:0] a0 = 16'($urandom);
      logic [15:0] b0 = 16'($urandom);
      logic [15:0] a1 = 16'($urandom);
      logic [15:0] b1 = 16'($urandom);
      logic [18:0] e0 = refSub(a0, b0, 1'b0);
      logic [18:0] e1 = refSub(a1, b1, 1'b1);
      iReady = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c < 4) iValid = pat[c];
         else       iValid = 1'b0;
         if (c == 0) begin in1 = a0; in2 = b0; bIn = 1'b0; end
         if (c == 3) begin in1 = a1; in2 = b1; bIn = 1'b1; end
         @(posedge clk);
         #1;
         if (c >= 5) begin
            nVectors++;
            if (oValid !== pat[c-5]) begin
               nMiscompares++;
               $display("[TB] FAIL bubble_valid c=%0d: got %b want %b", c, oValid, pat[c-5]);
            end
         end
         if (c == 5 || c == 6 || c == 7) begin
            nVectors++;
            if ({diffO, bOut, ovfO, zeroO} !== e0) begin
               nMiscompares++;
               $display("[TB] FAIL bubble_hold c=%0d: got %h want %h", c, {diffO, bOut, ovfO, zeroO}, e0);
            end
         end
         if (c == 8) begin
            nVectors++;
            if ({diffO, bOut, ovfO, zeroO} !== e1) begin
               nMiscompares++;
               $display("[TB] FAIL bubble_second: got %h want %h", {diffO, bOut, ovfO, zeroO}, e1);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [8];
      logic [15:0] vb [8];
      logic        vc [8];
      int          sent = 0;
      int          recv = 0;
      int          stallLeft = 0;
      bit          started = 1'b0;
      logic [19:0] held = '0;
      logic [18:0] exp;
      logic        inX, outX;
      for (int i = 0; i < 8; i++) begin
         va[i] = 16'($urandom);
         vb[i] = 16'($urandom);
         vc[i] = 1'($urandom_range(0, 1));
      end
      expQ.delete();
      for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
         if (sent < 8) begin
            iValid = 1'b1;
            in1 = va[sent];
            in2 = vb[sent];
            bIn = vc[sent];
         end else begin
            iValid = 1'b0;
         end
         if (!started && oValid) begin
            started   = 1'b1;
            stallLeft = 3;
            held      = {oValid, diffO, bOut, ovfO, zeroO};
         end
         iReady = (stallLeft == 0);
         @(negedge clk);
         if (stallLeft > 0) begin
            nVectors++;
            if (oReady !== 1'b0) begin
               nMiscompares++;
               $display("[TB] FAIL stall_ready: got %b want 0", oReady);
            end
            nVectors++;
            if ({oValid, diffO, bOut, ovfO, zeroO} !== held) begin
               nMiscompares++;
               $display("[TB] FAIL stall_hold: got %h want %h", {oValid, diffO, bOut, ovfO, zeroO}, held);
            end
         end
         inX  = iValid & oReady;
         outX = oValid & iReady;
         if (outX) begin
            nVectors++;
            if (expQ.size() == 0) begin
               nMiscompares++;
               $display("[TB] FAIL b2b_extra: got %h want none", {diffO, bOut, ovfO, zeroO});
            end else begin
               exp = expQ.pop_front();
               if ({diffO, bOut, ovfO, zeroO} !== exp) begin
                  nMiscompares++;
                  $display("[TB] FAIL b2b_result%0d: got %h want %h", recv, {diffO, bOut, ovfO, zeroO}, exp);
               end
            end
            recv++;
         end
         if (inX) begin
            expQ.push_back(refSub(in1, in2, bIn));
            sent++;
         end
         @(posedge clk);
         #1;
         if (stallLeft > 0) stallLeft--;
      end
      iValid = 1'b0;
      iReady = 1'b1;
      nVectors++;
      if (recv != 8) begin
         nMiscompares++;
         $display("[TB] FAIL b2b_count: got %0d want 8", recv);
      end
      @(posedge clk);
      #1;
      nVectors++;
      if (oValid !== 1'b0) begin
         nMiscompares++;
         $display("[TB] FAIL b2b_duplicate: got o_valid %b want 0", oValid);
      end
   endtask

   task automatic test_random();
      int          sent = 0;
      logic [18:0] exp;
      logic        inX, outX;
      expQ.delete();
      iValid = 1'b0;
      for (int cyc = 0; cyc < 800 && !(sent == 60 && expQ.size() == 0); cyc++) begin
         if (!iValid && sent < 60 && $urandom_range(0, 3) != 0) begin
            in1    = 16'($urandom);
            in2    = 16'($urandom);
            bIn    = 1'($urandom_range(0, 1));
            iValid = 1'b1;
         end
         iReady = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         nVectors++;
         if (oReady !== (iReady | ~oValid)) begin
            nMiscompares++;
            $display("[TB] FAIL rand_ready: got %b want %b", oReady, iReady | ~oValid);
         end
         inX  = iValid & oReady;
         outX = oValid & iReady;
         if (outX) begin
            nVectors++;
            if (expQ.size() == 0) begin
               nMiscompares++;
               $display("[TB] FAIL rand_extra: got %h want none", {diffO, bOut, ovfO, zeroO});
            end else begin
               exp = expQ.pop_front();
               if ({diffO, bOut, ovfO, zeroO} !== exp) begin
                  nMiscompares++;
                  $display("[TB] FAIL rand_result: got %h want %h", {diffO, bOut, ovfO, zeroO}, exp);
               end
            end
         end
         if (inX) begin
            expQ.push_back(refSub(in1, in2, bIn));
            sent++;
         end
         @(posedge clk);
         #1;
         if (inX) iValid = 1'b0;
      end
      iValid = 1'b0;
      iReady = 1'b1;
      nVectors++;
      if (sent != 60 || expQ.size() != 0) begin
         nMiscompares++;
         $display("[TB] FAIL rand_drain: got sent=%0d pending=%0d want sent=60 pending=0", sent, expQ.size());
      end
   endtask

   task automatic test_reset_midstream();
      logic [15:0] na = 16'($urandom);
      logic [15:0] nb = 16'($urandom);
      logic [18:0] ne = refSub(na, nb, 1'b1);
      iReady = 1'b1;
      for (int j = 0; j < 6; j++) begin
         if (j == 0) begin in1 = 16'h7FFF; in2 = 16'hFFFF; bIn = 1'b0; end
         else begin in1 = 16'($urandom); in2 = 16'($urandom); bIn = 1'($urandom_range(0, 1)); end
         iValid = 1'b1;
         @(posedge clk);
         #1;
      end
      iValid = 1'b0;
      nVectors++;
      if ({oValid, diffO, bOut, ovfO, zeroO} !== {1'b1, 16'h8000, 3'b110}) begin
         nMiscompares++;
         $display("[TB] FAIL midrst_before: got %h want %h", {oValid, diffO, bOut, ovfO, zeroO}, {1'b1, 16'h8000, 3'b110});
      end
      #2 rstN = 1'b0;
      #1;
      nVectors++;
      if ({oValid, diffO, bOut, ovfO, zeroO} !== 20'h0) begin
         nMiscompares++;
         $display("[TB] FAIL midrst_async: got %h want %h", {oValid, diffO, bOut, ovfO, zeroO}, 20'h0);
      end
      nVectors++;
      if (oReady !== 1'b1) begin
         nMiscompares++;
         $display("[TB] FAIL midrst_ready: got %b want 1", oReady);
      end
      @(posedge clk);
      #3 rstN = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         nVectors++;
         if (oValid !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL midrst_stale c=%0d: got %b want 0", c, oValid);
         end
      end
      in1 = na;
      in2 = nb;
      bIn = 1'b1;
      iValid = 1'b1;
      @(posedge clk);
      #1 iValid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      nVectors++;
      if (oValid !== 1'b0) begin
         nMiscompares++;
         $display("[TB] FAIL midrst_early: got %b want 0", oValid);
      end
      @(posedge clk);
      #1;
      nVectors++;
      if ({oValid, diffO, bOut, ovfO, zeroO} !== {1'b1, ne}) begin
         nMiscompares++;
         $display("[TB] FAIL midrst_first: got %h want %h", {oValid, diffO, bOut, ovfO, zeroO}, {1'b1, ne});
      end
   endtask

   initial begin
      rstN   = 1'b0;
      iValid = 1'b0;
      iReady = 1'b1;
      in1    = '0;
      in2    = '0;
      bIn    = 1'b0;
      test_reset();
      test_directed();
      test_bubbles();
      test_back_to_back();
      test_random();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/cla_sub_16bit_pipe.md
# cla_sub_16bit_pipe

Pipelined 16-bit subtractor built from four 4-bit carry-lookahead slices. It computes `in_1 - in_2 - b_in`, with one slice per pipeline stage and the borrow registered between stages, matching the stage structure of the 16-bit CLA adder. Unlike the free-running adder, it carries a valid/ready handshake with full-pipeline stall, so it can sit directly in the datapath between a producer and a back-pressuring consumer. It also reports borrow-out, signed overflow and zero.

## Interface
- Parameters: none. Width is fixed at 16 bits, as four 4-bit slices.
- `i_clk` input 1: single clock, rising edge.
- `i_rst_n` input 1: asynchronous active-low reset.
- `in_1` input 16: minuend.
- `in_2` input 16: subtrahend.
- `b_in` input 1: borrow in (1 = subtract an extra 1).
- `i_valid` input 1: operands valid.
- `o_ready` output 1: block accepts operands this cycle.
- `diff` output 16: result `in_1 - in_2 - b_in`, modulo 2^16.
- `b_out` output 1: unsigned borrow out (1 when `in_1 < in_2 + b_in`).
- `ovf` output 1: two's-complement signed overflow.
- `zero` output 1: `diff == 16'h0000`.
- `o_valid` output 1: result outputs valid.
- `i_ready` input 1: downstream accepts result.

## Operation
- Arithmetic: `diff` = `in_1 + ~in_2 + ~b_in`. The slice-0 carry-in is `~b_in`, and each slice's carry-out feeds the next stage registered. `b_out` = `~c_out` of slice 3.
- `ovf` = (`in_1[15] != in_2[15]`) && (`diff[15] != in_1[15]`). Bits 15 of both operands travel with the data to the stage-4 slice.
- `zero` is computed from the full 16-bit `diff` at the output-register load.
- Pipeline stages:
  - S0: input register for `in_1`, `in_2` and `b_in`.
  - S1 to S4: slice k (bits 4k+3:4k) evaluated combinationally from the operand bits delayed k stages and the registered borrow chain.
  - Completed sum nibbles are delayed so all four align at the output register.
  - Each stage has a valid bit.
- Global enable: `en = i_ready | ~o_valid`. `o_ready = en`, and it is combinational.
- Transfer rules:
  - Input transfer occurs when `i_valid & o_ready`.
  - Output transfer occurs when `o_valid & i_ready`.
- When `en` = 1, every stage register, including the valid bits, advances one step. S0's valid bit loads `i_valid`.
- When `en` = 0, all stage registers and outputs hold. No transaction is lost, duplicated or reordered.
- Bubbles (invalid stages) propagate as bubbles. They are not compressed out.
- Output registers (`diff`, `b_out`, `ovf`, `zero`) load only when `en` = 1 and the final stage holds valid data. Otherwise they keep their last value. `o_valid` tracks the final-stage valid bit.
- Reset (asynchronous, any time, including mid-stream or mid-stall):
  - All valid bits clear, so `o_valid` = 0.
  - `diff` = 16'h0000, `b_out` = 0, `ovf` = 0, `zero` = 0.
  - In-flight transactions are discarded.
  - `o_ready` = 1 while in reset (since `o_valid` = 0).
- After reset deasserts, operation resumes at the next rising edge.

## Timing
- Latency: an operand accepted at edge k produces `o_valid` = 1 with its result after edge k+5, provided no stalls occur. Each stall cycle adds one cycle.
- Throughput: one result per clock while `i_ready` = 1.
- Path constraint: the critical path is one 4-bit CLA slice plus nibble muxing. There is no combinational path from operand inputs to any output.
- `o_ready` depends combinationally on `i_ready` and the registered `o_valid` only.
- Simultaneous events:
  - An output transfer and an input transfer in the same cycle are both honoured.
  - With `i_valid` = 1 and `o_ready` = 0, the producer must hold its operands. The block samples nothing.

## Test plan
- Basic subtraction: `in_1`=16'h1234, `in_2`=16'h0234, `b_in`=0, one transfer. Required: after 5 edges `o_valid`=1, `diff`=16'h1000, `b_out`=0, `ovf`=0, `zero`=0.
- Unsigned underflow: 16'h0000 − 16'h0001, `b_in`=0. Required: `diff`=16'hFFFF, `b_out`=1, `ovf`=0. Separately, 16'h0005 − 16'h0005 with `b_in`=1: required `diff`=16'hFFFF, `b_out`=1, `zero`=0.
- Signed overflow and zero: 16'h8000 − 16'h0001. Required: `diff`=16'h7FFF, `b_out`=0, `ovf`=1. Separately, 16'h0006 − 16'h0005 with `b_in`=1: required `diff`=0, `zero`=1, `b_out`=0.
- Back-pressure: stream 8 back-to-back vectors, and drop `i_ready` for 3 cycles starting at the first `o_valid`. Required:
  - `o_ready`=0 during the stall.
  - Outputs are held during the stall.
  - All 8 results arrive in order with none dropped or duplicated, checked against a reference model.
- Bubbles: drive `i_valid` in the pattern 1,0,0,1. Required: `o_valid` follows the same pattern 5 cycles later, and `diff` holds its value during the bubbles.
- Reset mid-stream: assert `i_rst_n`=0 asynchronously between edges while 4 transactions are in flight. Required:
  - `o_valid`, `diff`, `b_out`, `ovf` and `zero` go to 0 immediately, without waiting for a clock edge.
  - After release, no stale results appear.
  - The first new input's result appears exactly 5 edges after acceptance.
